// File: rtl/r16_output_delay_align.sv
// Output-side delay and alignment stage for the radix-16 butterfly PE.
// Sixteen lane words travel together through a rigid DELAY-deep stall pipeline
// with one valid bit per stage; a beat counter marks the last beat of each FFT
// frame and a frame counter tallies completed frames.
module r16_output_delay_align #(
    parameter int D_WIDTH     = 64,
    parameter int DELAY       = 2,
    parameter int FRAME_BEATS = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] data_in0,
    input  logic [D_WIDTH-1:0] data_in1,
    input  logic [D_WIDTH-1:0] data_in2,
    input  logic [D_WIDTH-1:0] data_in3,
    input  logic [D_WIDTH-1:0] data_in4,
    input  logic [D_WIDTH-1:0] data_in5,
    input  logic [D_WIDTH-1:0] data_in6,
    input  logic [D_WIDTH-1:0] data_in7,
    input  logic [D_WIDTH-1:0] data_in8,
    input  logic [D_WIDTH-1:0] data_in9,
    input  logic [D_WIDTH-1:0] data_in10,
    input  logic [D_WIDTH-1:0] data_in11,
    input  logic [D_WIDTH-1:0] data_in12,
    input  logic [D_WIDTH-1:0] data_in13,
    input  logic [D_WIDTH-1:0] data_in14,
    input  logic [D_WIDTH-1:0] data_in15,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data0,
    output logic [D_WIDTH-1:0] out_data1,
    output logic [D_WIDTH-1:0] out_data2,
    output logic [D_WIDTH-1:0] out_data3,
    output logic [D_WIDTH-1:0] out_data4,
    output logic [D_WIDTH-1:0] out_data5,
    output logic [D_WIDTH-1:0] out_data6,
    output logic [D_WIDTH-1:0] out_data7,
    output logic [D_WIDTH-1:0] out_data8,
    output logic [D_WIDTH-1:0] out_data9,
    output logic [D_WIDTH-1:0] out_data10,
    output logic [D_WIDTH-1:0] out_data11,
    output logic [D_WIDTH-1:0] out_data12,
    output logic [D_WIDTH-1:0] out_data13,
    output logic [D_WIDTH-1:0] out_data14,
    output logic [D_WIDTH-1:0] out_data15,
    output logic               out_last,
    output logic [15:0]        frame_cnt
);

    localparam int            CW        = $clog2(FRAME_BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BEATS - 1);

    logic               stage_v [1:DELAY];
    logic [D_WIDTH-1:0] stage_d [1:DELAY][16];
    logic [D_WIDTH-1:0] lane_in [16];
    logic [CW-1:0]      beat_cnt;
    logic               adv;
    logic               out_fire;

    assign lane_in[0]  = data_in0;
    assign lane_in[1]  = data_in1;
    assign lane_in[2]  = data_in2;
    assign lane_in[3]  = data_in3;
    assign lane_in[4]  = data_in4;
    assign lane_in[5]  = data_in5;
    assign lane_in[6]  = data_in6;
    assign lane_in[7]  = data_in7;
    assign lane_in[8]  = data_in8;
    assign lane_in[9]  = data_in9;
    assign lane_in[10] = data_in10;
    assign lane_in[11] = data_in11;
    assign lane_in[12] = data_in12;
    assign lane_in[13] = data_in13;
    assign lane_in[14] = data_in14;
    assign lane_in[15] = data_in15;

    // The whole pipe moves only when the output slot is free or being drained;
    // a flush blocks movement so the flush-cycle input is dropped.
    assign adv      = (~stage_v[DELAY] | out_ready) & ~flush;
    assign in_ready = adv;

    assign out_valid = stage_v[DELAY];
    assign out_fire  = out_valid & out_ready;
    assign out_last  = out_valid & (beat_cnt == LAST_BEAT);

    assign out_data0  = stage_d[DELAY][0];
    assign out_data1  = stage_d[DELAY][1];
    assign out_data2  = stage_d[DELAY][2];
    assign out_data3  = stage_d[DELAY][3];
    assign out_data4  = stage_d[DELAY][4];
    assign out_data5  = stage_d[DELAY][5];
    assign out_data6  = stage_d[DELAY][6];
    assign out_data7  = stage_d[DELAY][7];
    assign out_data8  = stage_d[DELAY][8];
    assign out_data9  = stage_d[DELAY][9];
    assign out_data10 = stage_d[DELAY][10];
    assign out_data11 = stage_d[DELAY][11];
    assign out_data12 = stage_d[DELAY][12];
    assign out_data13 = stage_d[DELAY][13];
    assign out_data14 = stage_d[DELAY][14];
    assign out_data15 = stage_d[DELAY][15];

    // Rigid shift pipeline: bubbles travel with the data, flush kills only the valids.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= DELAY; k++) begin
                stage_v[k] <= 1'b0;
                for (int n = 0; n < 16; n++) begin
                    stage_d[k][n] <= '0;
                end
            end
        end else if (flush) begin
            for (int k = 1; k <= DELAY; k++) begin
                stage_v[k] <= 1'b0;
            end
        end else if (adv) begin
            stage_v[1] <= in_valid;
            if (in_valid) begin
                for (int n = 0; n < 16; n++) begin
                    stage_d[1][n] <= lane_in[n];
                end
            end
            for (int k = 2; k <= DELAY; k++) begin
                stage_v[k] <= stage_v[k-1];
                for (int n = 0; n < 16; n++) begin
                    stage_d[k][n] <= stage_d[k-1][n];
                end
            end
        end
    end

    // Beat position within the frame advances on each output handshake and wraps
    // naturally at the power-of-two frame size; flush restarts the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else if (flush) begin
            beat_cnt <= '0;
        end else if (out_fire) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (out_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_r16_output_delay_align.sv
// Scoreboard bench for r16_output_delay_align (DELAY = 2, FRAME_BEATS = 4).
// Each accepted beat pushes its lane-0 value; lane N of beat b is b*16+N.
module tb_r16_output_delay_align;

    localparam int DW = 64;
    localparam int FB = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic          out_last;
    logic [15:0]   frame_cnt;
    logic [DW-1:0] din [16];
    logic [DW-1:0] od  [16];
    logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [DW-1:0] out_data4, out_data5, out_data6, out_data7;
    logic [DW-1:0] out_data8, out_data9, out_data10, out_data11;
    logic [DW-1:0] out_data12, out_data13, out_data14, out_data15;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] sb [$];
    int            model_beat  = 0;
    int            model_frame = 0;
    logic          stall_prev  = 1'b0;
    logic [DW-1:0] held        = '0;
    logic [DW-1:0] next_tag    = '0;
    logic          mon_exp_ready;
    logic [DW-1:0] mon_base;

    assign od[0]  = out_data0;
    assign od[1]  = out_data1;
    assign od[2]  = out_data2;
    assign od[3]  = out_data3;
    assign od[4]  = out_data4;
    assign od[5]  = out_data5;
    assign od[6]  = out_data6;
    assign od[7]  = out_data7;
    assign od[8]  = out_data8;
    assign od[9]  = out_data9;
    assign od[10] = out_data10;
    assign od[11] = out_data11;
    assign od[12] = out_data12;
    assign od[13] = out_data13;
    assign od[14] = out_data14;
    assign od[15] = out_data15;

    r16_output_delay_align #(
        .D_WIDTH(DW), .DELAY(2), .FRAME_BEATS(FB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .data_in4(din[4]), .data_in5(din[5]), .data_in6(din[6]), .data_in7(din[7]),
        .data_in8(din[8]), .data_in9(din[9]), .data_in10(din[10]), .data_in11(din[11]),
        .data_in12(din[12]), .data_in13(din[13]), .data_in14(din[14]), .data_in15(din[15]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .out_data4(out_data4), .out_data5(out_data5), .out_data6(out_data6), .out_data7(out_data7),
        .out_data8(out_data8), .out_data9(out_data9), .out_data10(out_data10), .out_data11(out_data11),
        .out_data12(out_data12), .out_data13(out_data13), .out_data14(out_data14), .out_data15(out_data15),
        .out_last(out_last), .frame_cnt(frame_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge and returns whether the beat was taken.
    task automatic applyStimulus(input logic vld, input logic ordy, input logic fl, output logic acc);
        for (int n = 0; n < 16; n++) begin
            din[n] = next_tag * 64'd16 + DW'(n);
        end
        in_valid  = vld;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = vld & in_ready;
        @(posedge clk);
        if (vld) begin
            next_tag = next_tag + 64'd1;
        end
        #1;
    endtask

    task automatic drainPipe(input string tag);
        logic a;
        int   c;
        c = 0;
        while (sb.size() != 0 && c < 30) begin
            applyStimulus(1'b0, 1'b1, 1'b0, a);
            c++;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        checkOutput(tag, DW'(sb.size()), '0);
    endtask

    // Scoreboard monitor: samples on the falling edge, pops on output handshakes, pushes on accepts.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            model_beat  = 0;
            model_frame = 0;
            stall_prev  = 1'b0;
        end else begin
            checkOutput("frame_cnt", DW'(frame_cnt), DW'(model_frame));
            mon_exp_ready = (!out_valid || out_ready) && !flush;
            checkOutput("in_ready", DW'(in_ready), DW'(mon_exp_ready));
            checkOutput("out_last", DW'(out_last), DW'(out_valid && (model_beat == FB - 1)));
            if (stall_prev) begin
                checkOutput("hold_valid", DW'(out_valid), DW'(1'b1));
                checkOutput("hold_data", od[0], held);
            end
            if (out_valid && out_ready) begin
                checkOutput("beat_present", DW'(sb.size() != 0), DW'(1'b1));
                if (sb.size() != 0) begin
                    mon_base = sb.pop_front();
                    for (int n = 0; n < 16; n++) begin
                        checkOutput($sformatf("lane%0d", n), od[n], mon_base + DW'(n));
                    end
                end
                if (!flush) begin
                    if (model_beat == FB - 1) begin
                        model_beat  = 0;
                        model_frame = (model_frame + 1) % 65536;
                    end else begin
                        model_beat++;
                    end
                end
            end
            if (flush) begin
                model_beat = 0;
                sb.delete();
            end
            if (in_valid && mon_exp_ready) begin
                sb.push_back(din[0]);
            end
            stall_prev = out_valid && !out_ready && !flush;
            held       = od[0];
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence: reset, streaming, backpressure, bubbles, frame wrap, flush, reset mid-frame.
    initial begin
        logic          a;
        int            sent;
        int            c;
        logic          pat [8];
        logic [DW-1:0] resume_base;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        checkOutput("rst_valid", DW'(out_valid), '0);
        checkOutput("rst_last", DW'(out_last), '0);
        checkOutput("rst_frame", DW'(frame_cnt), '0);
        checkOutput("rst_data0", od[0], '0);
        checkOutput("rst_data15", od[15], '0);
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        checkOutput("rst_valid3", DW'(out_valid), '0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b1, 1'b0, a);
        checkOutput("t1_lat0", DW'(out_valid), '0);
        applyStimulus(1'b1, 1'b1, 1'b0, a);
        checkOutput("t1_lat1", DW'(out_valid), DW'(1'b1));
        checkOutput("t1_first", od[5], DW'(5));
        for (int i = 2; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, a);
            checkOutput("t1_stream", DW'(out_valid), DW'(1'b1));
        end
        drainPipe("t1_drain");

        sent = 0;
        c    = 0;
        while (sent < 6 && c < 40) begin
            applyStimulus(1'b1, !(c >= 4 && c <= 7), 1'b0, a);
            if (a) sent++;
            c++;
        end
        checkOutput("t2_sent", DW'(sent), DW'(6));
        drainPipe("t2_drain");

        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(pat[i], 1'b1, 1'b0, a);
            if (i >= 1) checkOutput($sformatf("t3_bubble%0d", i), DW'(out_valid), DW'(pat[i-1]));
        end
        drainPipe("t3_drain");

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        checkOutput("t4_rst_frame", DW'(frame_cnt), '0);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, a);
        drainPipe("t4_drain");
        checkOutput("t4_frames", DW'(frame_cnt), DW'(2));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, a);
        drainPipe("t4_drain2");
        checkOutput("t4_beatcnt", DW'(frame_cnt), DW'(3));

        applyStimulus(1'b1, 1'b1, 1'b0, a);
        applyStimulus(1'b1, 1'b1, 1'b0, a);
        applyStimulus(1'b1, 1'b1, 1'b1, a);
        checkOutput("t5_drop", DW'(a), '0);
        checkOutput("t5_valid", DW'(out_valid), '0);
        checkOutput("t5_frame", DW'(frame_cnt), DW'(3));
        resume_base = next_tag * 64'd16;
        applyStimulus(1'b1, 1'b1, 1'b0, a);
        checkOutput("t5_resume", DW'(a), DW'(1'b1));
        checkOutput("t5_lat0", DW'(out_valid), '0);
        applyStimulus(1'b1, 1'b1, 1'b0, a);
        checkOutput("t5_lat1", DW'(out_valid), DW'(1'b1));
        checkOutput("t5_data", od[0], resume_base);
        applyStimulus(1'b1, 1'b1, 1'b0, a);
        applyStimulus(1'b1, 1'b1, 1'b0, a);
        drainPipe("t5_drain");
        checkOutput("t5_frames", DW'(frame_cnt), DW'(4));

        applyStimulus(1'b1, 1'b1, 1'b0, a);
        applyStimulus(1'b1, 1'b1, 1'b0, a);
        drainPipe("t6_drain");
        applyStimulus(1'b1, 1'b0, 1'b0, a);
        applyStimulus(1'b1, 1'b0, 1'b0, a);
        checkOutput("t6_full", DW'(out_valid), DW'(1'b1));
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        checkOutput("t6_valid", DW'(out_valid), '0);
        checkOutput("t6_last", DW'(out_last), '0);
        checkOutput("t6_frame", DW'(frame_cnt), '0);
        checkOutput("t6_data0", od[0], '0);
        checkOutput("t6_data15", od[15], '0);
        checkOutput("t6_rst_ready", DW'(in_ready), DW'(1'b1));
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        applyStimulus(1'b0, 1'b1, 1'b0, a);
        checkOutput("t6_quiet", DW'(out_valid), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
